// File: rtl/axicb_slv_wr_sched_if.sv
// AW/W handshake and mux-select bundle between one crossbar slave port and its write scheduler.
// slave modport is the scheduler side; master modport is the switch/requester side.
interface axicb_slv_wr_sched_if #(
  parameter int MST_NB = 4
);
  logic [MST_NB-1:0] i_awvalid;
  logic [MST_NB-1:0] i_awready;
  logic              o_awvalid;
  logic              o_awready;
  logic [MST_NB-1:0] aw_grant;
  logic [MST_NB-1:0] i_wvalid;
  logic [MST_NB-1:0] i_wready;
  logic [MST_NB-1:0] i_wlast;
  logic              o_wvalid;
  logic              o_wready;
  logic              o_wlast;
  logic [MST_NB-1:0] w_grant;
  logic              fifo_full;
  logic              fifo_empty;

  modport slave (
    input  i_awvalid, o_awready, i_wvalid, i_wlast, o_wready,
    output i_awready, o_awvalid, aw_grant, i_wready, o_wvalid, o_wlast, w_grant,
           fifo_full, fifo_empty
  );

  modport master (
    output i_awvalid, o_awready, i_wvalid, i_wlast, o_wready,
    input  i_awready, o_awvalid, aw_grant, i_wready, o_wvalid, o_wlast, w_grant,
           fifo_full, fifo_empty
  );
endinterface

// File: rtl/axicb_slv_wr_sched.sv
// Slave-port write scheduler: priority+RR AW arbitration (1-cycle grant, 2-cycle issue interval),
// W routed in AW order from an order FIFO; a full FIFO stalls new AW grants, W stalls via o_wready.
module axicb_slv_wr_sched #(
  parameter int MST_NB        = 4,
  parameter int MST0_PRIORITY = 0,
  parameter int MST1_PRIORITY = 0,
  parameter int MST2_PRIORITY = 0,
  parameter int MST3_PRIORITY = 0,
  parameter int OSTDREQ_NUM   = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 srst,
  axicb_slv_wr_sched_if.slave  bus
);

  localparam int IW = (MST_NB > 1) ? $clog2(MST_NB) : 1;
  localparam int PW = $clog2(OSTDREQ_NUM);
  localparam int CW = PW + 1;
  localparam logic [1:0] PRIO [4] = '{2'(MST0_PRIORITY), 2'(MST1_PRIORITY),
                                      2'(MST2_PRIORITY), 2'(MST3_PRIORITY)};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [MST_NB-1:0] aw_grant_q;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     rr_ptr;

  logic [1:0]        top_lvl;
  logic [MST_NB-1:0] cand;
  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic [MST_NB-1:0] win_oh;

  logic [IW-1:0]     order_mem [OSTDREQ_NUM];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [MST_NB-1:0] w_sel;

  // Highest active level first, then the first candidate above rr_ptr, wrapping to the lowest index.
  always_comb begin
    top_lvl = '0;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int i = 0; i < MST_NB; i++) begin
      if (bus.i_awvalid[i] && (PRIO[i] > top_lvl)) top_lvl = PRIO[i];
    end
    for (int i = 0; i < MST_NB; i++) begin
      cand[i] = bus.i_awvalid[i] && (PRIO[i] == top_lvl);
    end
    for (int i = 0; i < MST_NB; i++) begin
      if (!win_vld && cand[i] && (IW'(i) > rr_ptr)) begin
        win_vld   = 1'b1;
        win_idx   = IW'(i);
        win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < MST_NB; i++) begin
      if (!win_vld && cand[i] && (IW'(i) <= rr_ptr)) begin
        win_vld   = 1'b1;
        win_idx   = IW'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  assign bus.o_awvalid = |(bus.i_awvalid & aw_grant_q);
  assign bus.i_awready = aw_grant_q & {MST_NB{bus.o_awready}};
  assign bus.aw_grant  = aw_grant_q;
  assign push          = bus.o_awvalid & bus.o_awready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      aw_grant_q <= '0;
      gnt_idx    <= '0;
      rr_ptr     <= IW'(MST_NB - 1);
    end else if (srst) begin
      state      <= IDLE;
      aw_grant_q <= '0;
      gnt_idx    <= '0;
      rr_ptr     <= IW'(MST_NB - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_vld && !full) begin
            state      <= GRANT;
            aw_grant_q <= win_oh;
            gnt_idx    <= win_idx;
          end
        end
        GRANT: begin
          // Grant is held until the handshake even if the master withdraws awvalid.
          if (push) begin
            state      <= IDLE;
            aw_grant_q <= '0;
            rr_ptr     <= gnt_idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full  = (count == CW'(OSTDREQ_NUM));
  assign empty = (count == '0);
  assign pop   = bus.o_wvalid & bus.o_wready & bus.o_wlast;

  always_ff @(posedge aclk) begin
    if (push) order_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Empty FIFO forces w_sel to zero, which also masks o_wvalid and so any pop.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < MST_NB; i++) begin
      w_sel[i] = !empty && (order_mem[rd_ptr] == IW'(i));
    end
  end

  assign bus.w_grant    = w_sel;
  assign bus.o_wvalid   = |(bus.i_wvalid & w_sel);
  assign bus.o_wlast    = |(bus.i_wlast & w_sel);
  assign bus.i_wready   = w_sel & {MST_NB{bus.o_wready}};
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;

endmodule
